// File: rtl/irq_pending_latch_pkg.sv
// rtl/irq_pending_latch_pkg.sv - shared sizes, FSM states and one-hot helper for irq_pending_latch
package irq_pkg;

  localparam int N_SRC = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  function automatic logic [N_SRC-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_SRC-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_pending_latch_if.sv
// rtl/irq_pending_latch_if.sv - valid/ready offer channel from the pending latch to the codec
interface irq_pending_latch_if;
  import irq_pkg::*;

  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic             out_ready;

  modport master (output out_valid, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_idx, output out_ready);

endinterface

// File: rtl/irq_pending_latch_prio_pick.sv
// rtl/irq_pending_latch_prio_pick.sv - combinational 8-to-3 highest-index picker with any flag
module irq_prio_pick
  import irq_pkg::*;
(
  input  logic [N_SRC-1:0] cand_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Ascending scan so the last hit, the highest index, wins.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (cand_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o = |cand_i;

endmodule

// File: rtl/irq_pending_latch.sv
// rtl/irq_pending_latch.sv - edge-detected sticky pending bits offered highest-index first
// Optional overflow flag built only when IRQ_OVF_EN is defined.
module irq_pending_latch
  import irq_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [N_SRC-1:0]     req_i,
  input  logic [N_SRC-1:0]     mask_i,
  output logic [N_SRC-1:0]     pend_o,
`ifdef IRQ_OVF_EN
  output logic                 ovf_o,
`endif
  irq_pending_latch_if.master  offer
);

  logic [N_SRC-1:0] req_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  state_e           state_q, state_d;

  logic [N_SRC-1:0] rise, clr, cand;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             accept;

  assign rise   = req_i & ~req_q;
  assign accept = (state_q == OFFER) && offer.out_ready;
  assign clr    = accept ? onehot(idx_q) : '0;
  // Set after clear: a fresh rise on the bit being accepted keeps it pending.
  assign pend_d = (pend_q & ~clr) | rise;
  assign cand   = pend_q & ~mask_i;

  irq_prio_pick u_pick (
    .cand_i (cand),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (en_i && pick_any) begin
          idx_d   = pick_idx;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (offer.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q   <= '0;
      pend_q  <= '0;
      idx_q   <= '0;
      state_q <= IDLE;
    end else begin
      req_q   <= req_i;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

`ifdef IRQ_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= ovf_q | (|(rise & pend_q & ~clr));
  end

  assign ovf_o = ovf_q;
`endif

  assign pend_o          = pend_q;
  assign offer.out_valid = (state_q == OFFER);
  assign offer.out_idx   = idx_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// tb/tb_irq_pending_latch.sv - directed and random checks of irq_pending_latch against a reference model
module tb_irq_pending_latch;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] mask;
  logic [7:0] pend;
`ifdef IRQ_OVF_EN
  logic       ovf;
`endif

  irq_pending_latch_if ifc ();

  irq_pending_latch dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (en),
    .req_i  (req),
    .mask_i (mask),
    .pend_o (pend),
`ifdef IRQ_OVF_EN
    .ovf_o  (ovf),
`endif
    .offer  (ifc.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: per-source pending flags, the current offer, and the last seen request level.
  bit m_pend [8];
  bit m_reqp [8];
  bit m_valid;
  int m_idx;
  bit m_ovf;

  task automatic model_edge();
    bit took;
    int best;
    if (rst) begin
      foreach (m_pend[i]) begin m_pend[i] = 0; m_reqp[i] = 0; end
      m_valid = 0; m_idx = 0; m_ovf = 0;
      return;
    end
    took = m_valid && ifc.out_ready;
    best = -1;
    if (!m_valid && en)
      for (int i = 7; i >= 0 && best < 0; i--)
        if (m_pend[i] && !mask[i]) best = i;
    for (int i = 0; i < 8; i++) begin
      bit rising, gone;
      rising = req[i] && !m_reqp[i];
      gone   = took && (m_idx == i);
      if (rising && m_pend[i] && !gone) m_ovf = 1;
      if (rising)    m_pend[i] = 1;
      else if (gone) m_pend[i] = 0;
      m_reqp[i] = req[i];
    end
    if (took) m_valid = 0;
    else if (best >= 0) begin m_valid = 1; m_idx = best; end
  endtask

  function automatic logic [7:0] model_pend();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("pend", pend, model_pend());
    check_eq("valid", ifc.out_valid, m_valid);
    check_eq("idx", ifc.out_idx, m_idx);
`ifdef IRQ_OVF_EN
    check_eq("ovf", ovf, m_ovf);
`endif
  endtask

  int got_q [$];

  initial begin
    rst = 1; en = 1; req = 0; mask = 0; ifc.out_ready = 0;
    tick(); tick();
    rst = 0;
    tick();
    check_eq("rst_pend", pend, 8'h00);
    check_eq("rst_valid", ifc.out_valid, 1'b0);
`ifdef IRQ_OVF_EN
    check_eq("rst_ovf", ovf, 1'b0);
`endif

    // Single request: pending one edge later, offered the edge after.
    req = 8'h04; tick();
    check_eq("t1_pend", pend, 8'h04);
    check_eq("t1_valid_early", ifc.out_valid, 1'b0);
    req = 8'h00; tick();
    check_eq("t1_valid", ifc.out_valid, 1'b1);
    check_eq("t1_idx", ifc.out_idx, 3'd2);
    ifc.out_ready = 1; tick(); ifc.out_ready = 0;

    // Priority order with ready held high.
    req = 8'hA4; ifc.out_ready = 1; tick(); req = 8'h00;
    for (int c = 0; c < 8; c++) begin
      if (ifc.out_valid) got_q.push_back(int'(ifc.out_idx));
      tick();
    end
    ifc.out_ready = 0;
    check_eq("t2_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check_eq("t2_first", got_q[0], 7);
      check_eq("t2_second", got_q[1], 5);
      check_eq("t2_third", got_q[2], 2);
    end
    check_eq("t2_pend", pend, 8'h00);

    // Backpressure: offer of 3 frozen while 6 arrives and 3 gets masked.
    req = 8'h08; tick(); req = 8'h00; tick();
    check_eq("t3_offer", ifc.out_idx, 3'd3);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin req = 8'h40; mask = 8'h08; end
      tick();
      check_eq("t3_hold_idx", ifc.out_idx, 3'd3);
      check_eq("t3_hold_valid", ifc.out_valid, 1'b1);
    end
    ifc.out_ready = 1; tick(); ifc.out_ready = 0;
    tick();
    check_eq("t3_next", ifc.out_idx, 3'd6);
    check_eq("t3_next_valid", ifc.out_valid, 1'b1);
    ifc.out_ready = 1; tick(); ifc.out_ready = 0;
    req = 8'h00; mask = 8'h00; tick();

    // Mask skips 7, then enable gates new offers.
    req = 8'h81; mask = 8'h80; tick(); tick();
    check_eq("t4_masked_idx", ifc.out_idx, 3'd0);
    ifc.out_ready = 1; tick(); ifc.out_ready = 0;
    en = 0; mask = 8'h00; req = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("t4_en_off", ifc.out_valid, 1'b0);
    end
    en = 1; tick();
    check_eq("t4_resume", ifc.out_idx, 3'd7);
    ifc.out_ready = 1; tick(); ifc.out_ready = 0;

    // Collision: acceptance and a fresh rise on the same bit.
    req = 8'h10; tick(); req = 8'h00; tick();
    check_eq("t5_offer", ifc.out_idx, 3'd4);
    ifc.out_ready = 1; req = 8'h10; tick(); ifc.out_ready = 0;
    check_eq("t5_pend_kept", pend[4], 1'b1);
    tick();
    check_eq("t5_reoffer", ifc.out_idx, 3'd4);
`ifdef IRQ_OVF_EN
    check_eq("t5_no_ovf", ovf, 1'b0);
`endif
    ifc.out_ready = 1; tick(); ifc.out_ready = 0; req = 8'h00; tick();

`ifdef IRQ_OVF_EN
    // Second pulse before acceptance overflows and sticks until reset.
    req = 8'h02; tick(); req = 8'h00; tick(); req = 8'h02; tick(); req = 8'h00; tick();
    check_eq("t6_ovf", ovf, 1'b1);
    ifc.out_ready = 1; tick(); ifc.out_ready = 0; tick();
    check_eq("t6_ovf_sticky", ovf, 1'b1);
    rst = 1; tick(); rst = 0;
    check_eq("t6_ovf_rst", ovf, 1'b0);
`endif

    // Random traffic, including occasional mid-offer resets.
    for (int c = 0; c < 400; c++) begin
      rst           = ($urandom_range(0, 99) == 0);
      en            = ($urandom_range(0, 7) != 0);
      req           = 8'($urandom);
      mask          = 8'($urandom) & 8'($urandom);
      ifc.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
